// File: rtl/fp32_mat_pkg.sv
// Shared types and width helpers for the fp32 flat-matrix streaming blocks.
package fp32_mat_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  localparam int TAG_FIELD_W = 16;

  // Width-agnostic element tag for blocks that pass tags between modules.
  typedef struct packed {
    logic [TAG_FIELD_W-1:0] r;
    logic [TAG_FIELD_W-1:0] c;
    logic [TAG_FIELD_W-1:0] idx;
    logic                   row_last;
    logic                   last;
  } elem_tag_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fp32_mat_idx_counter.sv
// Row/column/flat-index walker over a ROWS x COLS matrix, row- or column-major.
module fp32_mat_idx_counter
  import fp32_mat_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  localparam int N     = ROWS * COLS,
  localparam int ROW_W = clog2_min1(ROWS),
  localparam int COL_W = clog2_min1(COLS),
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic             col_major_i,
  output logic [ROW_W-1:0] r_o,
  output logic [COL_W-1:0] c_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             row_last_o,
  output logic             last_o
);

  localparam logic [ROW_W-1:0] R_MAX  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] C_MAX  = COL_W'(COLS - 1);
  localparam logic [IDX_W-1:0] I_MAX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] I_STEP = IDX_W'(COLS);

  logic [ROW_W-1:0] r_q, r_d;
  logic [COL_W-1:0] c_q, c_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cm_q, cm_d;

  always_comb begin
    r_d   = r_q;
    c_d   = c_q;
    idx_d = idx_q;
    cm_d  = cm_q;
    if (clr_i) begin
      r_d   = '0;
      c_d   = '0;
      idx_d = '0;
      cm_d  = col_major_i;
    end else if (adv_i) begin
      if (cm_q) begin
        // Column walk: the flat index steps by COLS and restarts at the top of the next column.
        if (r_q == R_MAX) begin
          r_d   = '0;
          c_d   = c_q + 1'b1;
          idx_d = IDX_W'(c_q) + 1'b1;
        end else begin
          r_d   = r_q + 1'b1;
          idx_d = idx_q + I_STEP;
        end
      end else begin
        idx_d = idx_q + 1'b1;
        if (c_q == C_MAX) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      c_q   <= '0;
      idx_q <= '0;
      cm_q  <= 1'b0;
    end else begin
      r_q   <= r_d;
      c_q   <= c_d;
      idx_q <= idx_d;
      cm_q  <= cm_d;
    end
  end

  assign r_o        = r_q;
  assign c_o        = c_q;
  assign idx_o      = idx_q;
  assign row_last_o = cm_q ? (r_q == R_MAX) : (c_q == C_MAX);
  assign last_o     = (idx_q == I_MAX);

endmodule

// File: rtl/fp32_matrix_flat_streamer.sv
// Snapshots a row-major flat fp32 matrix on start and streams it one tagged element per beat.
// Optional column-major traversal with macro FP32_MAT_STREAM_TRANSPOSE_EN (adds col_major input).
module fp32_matrix_flat_streamer
  import fp32_mat_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 32,
  localparam int N     = ROWS * COLS,
  localparam int ROW_W = clog2_min1(ROWS),
  localparam int COL_W = clog2_min1(COLS),
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
`ifdef FP32_MAT_STREAM_TRANSPOSE_EN
  input  logic                col_major,
`endif
  input  logic [DATA_W*N-1:0] in_flat,
  output logic                busy,
  output logic                done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [ROW_W-1:0]    out_r,
  output logic [COL_W-1:0]    out_c,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_row_last,
  output logic                out_last
);

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic [DATA_W-1:0] snap_q [N];

  logic load;
  logic hs;
  logic adv;
  logic cm_sel;

  assign load = (state_q == S_IDLE) && start;
  assign hs   = (state_q == S_STREAM) && valid_q && out_ready && !abort;
  // The walker parks on the final element so out_idx never leaves the snapshot range.
  assign adv  = hs && !out_last;

`ifdef FP32_MAT_STREAM_TRANSPOSE_EN
  assign cm_sel = col_major;
`else
  assign cm_sel = 1'b0;
`endif

  fp32_mat_idx_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (load),
    .adv_i      (adv),
    .col_major_i(cm_sel),
    .r_o        (out_r),
    .c_o        (out_c),
    .idx_o      (out_idx),
    .row_last_o (out_row_last),
    .last_o     (out_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) snap_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) snap_q[i] <= in_flat[DATA_W*i +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_STREAM;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        S_STREAM: begin
          // Abort wins over a handshake landing in the same cycle.
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else if (hs && out_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_data  = snap_q[out_idx];

endmodule

// File: tb/tb_fp32_matrix_flat_streamer.sv
// Scoreboard bench for fp32_matrix_flat_streamer: 2x3 main instance plus a 1x1 corner instance.
module tb_fp32_matrix_flat_streamer;

  localparam int ROWS   = 2;
  localparam int COLS   = 3;
  localparam int DATA_W = 32;
  localparam int N      = ROWS * COLS;
  localparam int ROW_W  = (ROWS <= 2) ? 1 : $clog2(ROWS);
  localparam int COL_W  = (COLS <= 2) ? 1 : $clog2(COLS);
  localparam int IDX_W  = (N <= 2) ? 1 : $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                col_major = 1'b0;
  logic [DATA_W*N-1:0] in_flat = '0;
  logic                busy, done, out_valid;
  logic                out_ready = 1'b0;
  logic [DATA_W-1:0]   out_data;
  logic [ROW_W-1:0]    out_r;
  logic [COL_W-1:0]    out_c;
  logic [IDX_W-1:0]    out_idx;
  logic                out_row_last, out_last;

  fp32_matrix_flat_streamer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
`ifdef FP32_MAT_STREAM_TRANSPOSE_EN
    .col_major   (col_major),
`endif
    .in_flat     (in_flat),
    .busy        (busy),
    .done        (done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_r       (out_r),
    .out_c       (out_c),
    .out_idx     (out_idx),
    .out_row_last(out_row_last),
    .out_last    (out_last)
  );

  logic        s1_start = 1'b0;
  logic        s1_abort = 1'b0;
  logic        s1_cm = 1'b0;
  logic [31:0] s1_flat = '0;
  logic        s1_busy, s1_done, s1_valid;
  logic        s1_ready = 1'b0;
  logic [31:0] s1_data;
  logic [0:0]  s1_r, s1_c, s1_idx;
  logic        s1_rl, s1_last;

  fp32_matrix_flat_streamer #(.ROWS(1), .COLS(1), .DATA_W(32)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .start       (s1_start),
    .abort       (s1_abort),
`ifdef FP32_MAT_STREAM_TRANSPOSE_EN
    .col_major   (s1_cm),
`endif
    .in_flat     (s1_flat),
    .busy        (s1_busy),
    .done        (s1_done),
    .out_valid   (s1_valid),
    .out_ready   (s1_ready),
    .out_data    (s1_data),
    .out_r       (s1_r),
    .out_c       (s1_c),
    .out_idx     (s1_idx),
    .out_row_last(s1_rl),
    .out_last    (s1_last)
  );

  typedef struct {
    logic [31:0] data;
    int          r;
    int          c;
    int          idx;
    bit          rl;
    bit          last;
  } beat_t;

  beat_t       expq[$];
  logic [31:0] mat [N];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference order derived directly from matrix coordinates.
  task automatic push_matrix(input bit cm);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      if (cm) begin
        b.c = k / ROWS;
        b.r = k % ROWS;
      end else begin
        b.r = k / COLS;
        b.c = k % COLS;
      end
      b.idx  = b.r * COLS + b.c;
      b.data = mat[b.idx];
      b.rl   = cm ? (b.r == ROWS - 1) : (b.c == COLS - 1);
      b.last = (b.idx == N - 1);
      expq.push_back(b);
    end
  endtask

  // Cycle-level expectation and consumer-side monitor.
  bit          exp_valid = 0, exp_done = 0, held_vld = 0;
  bit          nv, nd;
  beat_t       pb;
  logic [31:0] h_data;
  logic [63:0] h_r, h_c, h_idx;
  logic        h_rl, h_last;

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      exp_valid = 0;
      exp_done  = 0;
      held_vld  = 0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("busy", 64'(busy), 64'(exp_valid));
      chk("done", 64'(done), 64'(exp_done));
      if (held_vld && out_valid) begin
        chk("stall_data", 64'(out_data), 64'(h_data));
        chk("stall_r", 64'(out_r), h_r);
        chk("stall_c", 64'(out_c), h_c);
        chk("stall_idx", 64'(out_idx), h_idx);
        chk("stall_row_last", 64'(out_row_last), 64'(h_rl));
        chk("stall_last", 64'(out_last), 64'(h_last));
      end
      held_vld = 0;
      nv = exp_valid;
      nd = 0;
      if (exp_valid) begin
        if (abort) begin
          expq.delete();
          nv = 0;
        end else if (out_ready) begin
          if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL beat_extra: got idx %0d expected no beat at %0t", out_idx, $time);
          end else begin
            pb = expq.pop_front();
            chk("out_data", 64'(out_data), 64'(pb.data));
            chk("out_r", 64'(out_r), 64'(pb.r));
            chk("out_c", 64'(out_c), 64'(pb.c));
            chk("out_idx", 64'(out_idx), 64'(pb.idx));
            chk("out_row_last", 64'(out_row_last), 64'(pb.rl));
            chk("out_last", 64'(out_last), 64'(pb.last));
            if (pb.last) begin
              nv = 0;
              nd = 1;
            end
          end
        end else begin
          h_data   = out_data;
          h_r      = 64'(out_r);
          h_c      = 64'(out_c);
          h_idx    = 64'(out_idx);
          h_rl     = out_row_last;
          h_last   = out_last;
          held_vld = 1;
        end
      end else if (!exp_done && start) begin
        nv = 1;
      end
      exp_valid = nv;
      exp_done  = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flat();
    for (int i = 0; i < N; i++) in_flat[DATA_W*i +: DATA_W] = mat[i];
  endtask

  task automatic start_stream(input bit cm);
    load_flat();
    col_major = cm;
    start = 1'b1;
    push_matrix(cm);
    tick();
    start = 1'b0;
  endtask

  // mode: 0 ready high, 1 ready 1,0,0 repeating, 2 random.
  // inj: 1 overwrite in_flat, 2 start mid-stream, 3 abort, 4 reset mid-stream.
  task automatic run(input int mode, input int inj);
    bit ended = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc - 1) % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (inj == 1 && cyc == 2)
        for (int i = 0; i < N; i++) in_flat[DATA_W*i +: DATA_W] = 32'hDEADBEEF;
      start = (inj == 2 && cyc == 3);
      abort = (inj == 3 && cyc == 2);
      rst   = (inj == 4 && cyc == 3);
      tick();
      if (inj >= 3 && cyc == 5) begin
        ended = 1;
        break;
      end
      if (done) begin
        out_ready = 1'b0;
        tick();
        ended = 1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
    if (!ended) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_timeout: got no done expected done within 200 cycles (mode %0d inj %0d)", mode, inj);
    end
  endtask

  task automatic ramp();
    for (int i = 0; i < N; i++) mat[i] = 32'h3F800000 + 32'(i);
  endtask

  task automatic randmat();
    for (int i = 0; i < N; i++) mat[i] = $urandom;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_r", 64'(out_r), 64'd0);
    chk("rst_c", 64'(out_c), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_row_last", 64'(out_row_last), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    tick();

    ramp();
    start_stream(1'b0);
    run(0, 0);
    start_stream(1'b0);
    run(1, 0);
    start_stream(1'b0);
    run(0, 1);
    start_stream(1'b0);
    run(0, 2);
    start_stream(1'b0);
    run(0, 3);
    randmat();
    start_stream(1'b0);
    run(0, 0);
    randmat();
    start_stream(1'b0);
    run(0, 4);
    tick();
    for (int t = 0; t < 6; t++) begin
      randmat();
`ifdef FP32_MAT_STREAM_TRANSPOSE_EN
      start_stream(1'($urandom_range(0, 1)));
`else
      start_stream(1'b0);
`endif
      run(2, 0);
    end
`ifdef FP32_MAT_STREAM_TRANSPOSE_EN
    ramp();
    start_stream(1'b1);
    run(0, 0);
    start_stream(1'b1);
    run(1, 0);
`endif

    s1_flat  = $urandom;
    s1_ready = 1'b1;
    s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    chk("s1_valid", 64'(s1_valid), 64'd1);
    chk("s1_busy", 64'(s1_busy), 64'd1);
    chk("s1_data", 64'(s1_data), 64'(s1_flat));
    chk("s1_row_last", 64'(s1_rl), 64'd1);
    chk("s1_last", 64'(s1_last), 64'd1);
    chk("s1_idx", 64'(s1_idx), 64'd0);
    chk("s1_done_early", 64'(s1_done), 64'd0);
    tick();
    chk("s1_valid_after", 64'(s1_valid), 64'd0);
    chk("s1_done", 64'(s1_done), 64'd1);
    chk("s1_busy_done", 64'(s1_busy), 64'd0);
    tick();
    chk("s1_done_pulse", 64'(s1_done), 64'd0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
